serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter WIDTH, default 8, shall set the number of payload bits per frame (legal range 1..32).
REQ-002 Parameter CLKS_PER_BIT, default 4, shall set the number of clk cycles each serial bit is held (legal range 1..255).
REQ-003 clk  input  1  clock; all state shall change on the rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 tx_data  input  WIDTH  parallel word to transmit.
REQ-006 tx_valid  input  1  tx_data is valid this cycle.
REQ-007 tx_ready  output  1  block accepts a word this cycle.
REQ-008 sdo  output  1  serial data line; idle level 1.
REQ-009 busy  output  1  high while a frame is in progress.
REQ-010 done  output  1  single-cycle pulse after the last stop-bit cycle.

Function
REQ-011 A frame shall be: start bit 0, WIDTH payload bits LSB first, optional parity bit (REQ-026), stop bit 1.
REQ-012 The FSM shall have the states IDLE, START, DATA, PARITY, STOP.
REQ-013 Word acceptance shall occur on a rising edge where tx_valid=1 and tx_ready=1; tx_data shall be captured into an internal shift register on that edge.
REQ-014 tx_ready shall be 1 only in IDLE; it shall not depend combinationally on tx_valid.
REQ-015 On acceptance the FSM shall go IDLE->START; sdo shall be 0 starting the next cycle.
REQ-016 Each bit state shall last exactly CLKS_PER_BIT cycles, timed by a bit counter that is cleared on every state entry.
REQ-017 DATA shall shift out WIDTH bits, shifting the register right once per bit period; sdo shall equal register bit 0.
REQ-018 Sequencing: after DATA go to PARITY if enabled, otherwise to STOP; after STOP go to IDLE.
REQ-019 done shall be 1 for exactly one cycle, the first IDLE cycle after STOP; tx_ready shall also be 1 in that cycle.
REQ-020 A word may be accepted in the same cycle done=1, giving back-to-back frames with no idle gap.
REQ-021 busy shall be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-022 tx_data/tx_valid changes during a frame shall have no effect on the frame in flight.
REQ-023 Latency: from the acceptance edge, the first sdo=0 cycle is at +1; total frame = (WIDTH+2[+1 parity])*CLKS_PER_BIT cycles.

Reset
REQ-024 While rst=0 at a rising edge, the next state shall be: FSM=IDLE, sdo=1, busy=0, done=0, tx_ready=1, counters=0, shift register=0.
REQ-025 Reset asserted mid-frame shall abort the frame at the next edge; no done pulse shall be produced for the aborted frame.

Configuration
REQ-026 With macro SERIAL_TX_PARITY_EN defined, PARITY shall be inserted and sdo shall carry even parity (XOR of the captured WIDTH bits) for CLKS_PER_BIT cycles.
REQ-027 Without SERIAL_TX_PARITY_EN, the PARITY state and parity logic shall be absent, and DATA shall go directly to STOP.

Verification
REQ-028 Reset: hold rst=0 for 3 cycles mid-frame, then release -> sdo=1, busy=0, tx_ready=1, done=0, no done pulse.
REQ-029 Single frame, WIDTH=8, CLKS_PER_BIT=4, no parity: send 0xA5 -> sdo=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles; done at cycle 41 after acceptance.
REQ-030 Parity build, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame length 44 cycles.
REQ-031 Back-to-back: hold tx_valid=1 with 0x55 then 0x0F -> second start bit immediately follows the first stop bit, no idle cycle.
REQ-032 Input change mid-frame: change tx_data to 0xFF during DATA with tx_valid=1 -> in-flight frame unchanged; 0xFF is accepted only at done.
REQ-033 CLKS_PER_BIT=1, WIDTH=1: send 1 -> sdo sequence 0,1,1 and done pulse on the next cycle.

Source files
------------

// File: rtl/serial_tx_if.sv
// rtl/serial_tx_if.sv - word handshake between a producer and serial_tx
interface serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - framed serial transmitter; defining SERIAL_TX_PARITY_EN inserts an even-parity bit
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  serial_tx_if.slave tx,
  output logic       sdo,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [5:0] IDX_LAST = 6'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [7:0]       bit_cnt;
  logic [5:0]       idx;
  logic [WIDTH-1:0] shreg;
  logic             bit_end;
  logic             accept;
`ifdef SERIAL_TX_PARITY_EN
  logic             par;
`endif

  assign tx.tx_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = tx.tx_valid && tx.tx_ready;
  assign bit_end     = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (accept) state_nx = START;
      START:  if (bit_end) state_nx = DATA;
      DATA:   if (bit_end && idx == IDX_LAST)
`ifdef SERIAL_TX_PARITY_EN
                state_nx = PARITY;
      PARITY: if (bit_end) state_nx = STOP;
`else
                state_nx = STOP;
`endif
      STOP:   if (bit_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Every state exit happens on bit_end, so clearing there also clears on state entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt <= '0;
      idx     <= '0;
      shreg   <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == STOP) && bit_end;

      if (state == IDLE || bit_end) bit_cnt <= '0;
      else                          bit_cnt <= bit_cnt + 8'd1;

      if (state != DATA || (bit_end && idx == IDX_LAST)) idx <= '0;
      else if (bit_end)                                  idx <= idx + 6'd1;

      if (accept)                          shreg <= tx.tx_data;
      else if (state == DATA && bit_end)   shreg <= shreg >> 1;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst)        par <= 1'b0;
    else if (accept) par <= ^tx.tx_data;
  end
`endif

  always_comb begin
    sdo = 1'b1;
    case (state)
      START:  sdo = 1'b0;
      DATA:   sdo = shreg[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY: sdo = par;
`endif
      default: sdo = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed bench for serial_tx (8-bit/4-clk and 1-bit/1-clk instances)
module tb_serial_tx;

  localparam int W = 8;
  localparam int C = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB  = W + 2 + PB;
  localparam int NB1 = 3 + PB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_tx_if #(.WIDTH(8)) if8 ();
  serial_tx_if #(.WIDTH(1)) if1 ();

  logic sdo8, busy8, done8;
  logic sdo1, busy1, done1;

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut8 (
    .clk(clk), .rst(rst), .tx(if8), .sdo(sdo8), .busy(busy8), .done(done8)
  );

  serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .tx(if1), .sdo(sdo1), .busy(busy1), .done(done1)
  );

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs [6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic exp_bit8(input logic [7:0] d, input logic p, input int j);
    if (j == 0) return 1'b0;
    if (j <= W) return d[j-1];
    if (PB == 1 && j == W + 1) return p;
    return 1'b1;
  endfunction

  // Entered at the first cycle after acceptance; returns in the done cycle.
  task automatic check_frame8(input logic [7:0] d, input logic p, input int chg_at);
    for (int j = 0; j < NB; j++) begin
      for (int c = 0; c < C; c++) begin
        if (j * C + c == chg_at) begin
          if8.tx_data  = 8'hFF;
          if8.tx_valid = 1'b1;
        end
        check($sformatf("sdo %02h bit%0d cyc%0d", d, j, c), sdo8, exp_bit8(d, p, j));
        check("busy in frame", busy8, 1'b1);
        check("ready in frame", if8.tx_ready, 1'b0);
        check("done in frame", done8, 1'b0);
        @(negedge clk);
      end
    end
    check("done pulse", done8, 1'b1);
    check("ready at done", if8.tx_ready, 1'b1);
    check("busy at done", busy8, 1'b0);
    check("sdo idle at done", sdo8, 1'b1);
  endtask

  task automatic send8(input logic [7:0] d);
    check("ready before send", if8.tx_ready, 1'b1);
    if8.tx_data  = d;
    if8.tx_valid = 1'b1;
    @(negedge clk);
    if8.tx_valid = 1'b0;
  endtask

  logic [3:0] exp1;
  logic       saw_done;

  initial begin
    if8.tx_data  = '0;
    if8.tx_valid = 1'b0;
    if1.tx_data  = '0;
    if1.tx_valid = 1'b0;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h80, 1'b1};
    vecs[4] = '{8'h07, 1'b1};
    vecs[5] = '{8'h03, 1'b0};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset sdo8", sdo8, 1'b1);
    check("reset busy8", busy8, 1'b0);
    check("reset done8", done8, 1'b0);
    check("reset ready8", if8.tx_ready, 1'b1);
    check("reset sdo1", sdo1, 1'b1);
    check("reset ready1", if1.tx_ready, 1'b1);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send8(vecs[i].data);
      check_frame8(vecs[i].data, vecs[i].par, -1);
      @(negedge clk);
      check("done single cycle", done8, 1'b0);
      check("sdo idle after frame", sdo8, 1'b1);
    end

    // Back-to-back: valid stays high, second word is taken in the done cycle
    check("ready before b2b", if8.tx_ready, 1'b1);
    if8.tx_data  = 8'h55;
    if8.tx_valid = 1'b1;
    @(negedge clk);
    if8.tx_data = 8'h0F;
    check_frame8(8'h55, 1'b0, -1);
    @(negedge clk);
    if8.tx_valid = 1'b0;
    check_frame8(8'h0F, 1'b0, -1);
    @(negedge clk);
    check("done single after b2b", done8, 1'b0);

    // Input change during DATA must not disturb the frame in flight
    send8(8'hA5);
    check_frame8(8'hA5, 1'b0, 10);
    @(negedge clk);
    if8.tx_valid = 1'b0;
    check_frame8(8'hFF, 1'b0, -1);
    @(negedge clk);
    check("done single after change", done8, 1'b0);

    // Minimal configuration: one payload bit, one clock per bit
    exp1 = (PB == 1) ? 4'b1110 : 4'b0110;
    check("ready1 before send", if1.tx_ready, 1'b1);
    if1.tx_data  = 1'b1;
    if1.tx_valid = 1'b1;
    @(negedge clk);
    if1.tx_valid = 1'b0;
    for (int j = 0; j < NB1; j++) begin
      check($sformatf("sdo1 bit%0d", j), sdo1, exp1[j]);
      check("busy1 in frame", busy1, 1'b1);
      check("done1 in frame", done1, 1'b0);
      @(negedge clk);
    end
    check("done1 pulse", done1, 1'b1);
    check("busy1 at done", busy1, 1'b0);
    @(negedge clk);
    check("done1 single cycle", done1, 1'b0);

    // Reset during DATA aborts the frame without a done pulse
    send8(8'hA5);
    repeat (10) @(negedge clk);
    check("busy before abort", busy8, 1'b1);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort sdo", sdo8, 1'b1);
      check("abort busy", busy8, 1'b0);
      check("abort ready", if8.tx_ready, 1'b1);
      check("abort done", done8, 1'b0);
    end
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done8) saw_done = 1'b1;
    end
    check("no done after abort", saw_done, 1'b0);
    check("idle after abort busy", busy8, 1'b0);
    check("idle after abort sdo", sdo8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
